// File: rtl/scan_mux_nch.sv
// rtl/scan_mux_nch.sv - registered N-channel selector with manual select and masked auto-scan
//
// Optional build macro: SCAN_MUX_BLANK_EN
//   When defined, every auto-scan advance that changes cur_sel is followed by
//   two blanked cycles (dout=0, valid=0) before the new channel is driven.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   mode         in   0 = manual select, 1 = auto scan
//   sel_in       in   [SEL_W]      channel index used in manual mode
//   en_mask      in   [NCH]        per-channel auto-scan enable
//   din          in   [NCH*WIDTH]  flattened channel data, channel i at din[i*WIDTH +: WIDTH]
//   dout         out  [WIDTH]      registered selected data
//   cur_sel      out  [SEL_W]      index of the channel currently on dout
//   valid        out  dout holds live channel data
//   chan_strobe  out  one-cycle pulse on the cycle cur_sel takes a new value

module scan_mux_nch #(
    parameter int WIDTH  = 16,
    parameter int NCH    = 4,
    parameter int SEL_W  = 2,
    parameter int PERIOD = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic [SEL_W-1:0]       sel_in,
    input  logic [NCH-1:0]         en_mask,
    input  logic [NCH*WIDTH-1:0]   din,
    output logic [WIDTH-1:0]       dout,
    output logic [SEL_W-1:0]       cur_sel,
    output logic                   valid,
    output logic                   chan_strobe
);

    // Smallest counter width that can hold PERIOD-1.
    localparam int PW = (PERIOD >= 2) ? $clog2(PERIOD) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PERIOD - 1);

    // True when idx names a physically present channel.
    function automatic logic in_range(input logic [SEL_W-1:0] idx);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (idx == SEL_W'(i)) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    // Data of channel idx; zero for an index beyond the last channel.
    function automatic logic [WIDTH-1:0] chan_data(input logic [SEL_W-1:0]     idx,
                                                   input logic [NCH*WIDTH-1:0] bus);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) begin
            if (idx == SEL_W'(i)) begin
                r = bus[i*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    // Enable bit of channel idx; zero for an index beyond the last channel.
    function automatic logic chan_en(input logic [SEL_W-1:0] idx,
                                     input logic [NCH-1:0]   mask);
        logic r;
        r = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (idx == SEL_W'(i)) begin
                r = mask[i];
            end
        end
        return r;
    endfunction

    // Next enabled channel after base in circular order, excluding base itself.
    // The lowest enabled index above base wins; failing that, the lowest
    // enabled index below base (the wrap). With nothing else enabled, base holds.
    function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] base,
                                                      input logic [NCH-1:0]   mask);
        logic [SEL_W-1:0] r;
        logic             found;
        r     = base;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && mask[i] && (SEL_W'(i) > base)) begin
                r     = SEL_W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!found && mask[i] && (SEL_W'(i) < base)) begin
                r     = SEL_W'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic             mode_q;
    logic             tick;
    logic [SEL_W-1:0] sel_d;
    logic [WIDTH-1:0] dout_d;
    logic             valid_d;

`ifdef SCAN_MUX_BLANK_EN
    typedef enum logic [1:0] {
        ST_RUN,
        ST_BLANK1,
        ST_BLANK2
    } blank_state_t;

    blank_state_t state_q;
    blank_state_t state_d;
`endif

    always_comb begin
        presc_d = '0;
        tick    = 1'b0;
        sel_d   = cur_sel;
        dout_d  = '0;
        valid_d = 1'b0;
`ifdef SCAN_MUX_BLANK_EN
        state_d = ST_RUN;
`endif
        if (!mode) begin
            // Manual: follow sel_in directly; an absent channel reads as invalid zero.
            sel_d   = sel_in;
            dout_d  = chan_data(sel_in, din);
            valid_d = in_range(sel_in);
        end else begin
            if (!mode_q) begin
                // Entering auto: restart the slot, resume from the current
                // channel, or from channel 0 if the manual index was out of range.
                presc_d = '0;
                sel_d   = in_range(cur_sel) ? cur_sel : '0;
            end else begin
                tick    = (presc_q == PRESC_LAST);
                presc_d = tick ? '0 : presc_q + 1'b1;
                if (tick) begin
                    sel_d = next_enabled(cur_sel, en_mask);
                end
            end
            // A masked current channel blanks at once; it is left at the next tick.
            valid_d = chan_en(sel_d, en_mask);
            dout_d  = valid_d ? chan_data(sel_d, din) : '0;
`ifdef SCAN_MUX_BLANK_EN
            if (tick && (sel_d != cur_sel)) begin
                state_d = ST_BLANK1;
            end else if (state_q == ST_BLANK1) begin
                state_d = ST_BLANK2;
            end
            if (state_d != ST_RUN) begin
                dout_d  = '0;
                valid_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            mode_q      <= 1'b0;
            cur_sel     <= '0;
            dout        <= '0;
            valid       <= 1'b0;
            chan_strobe <= 1'b0;
`ifdef SCAN_MUX_BLANK_EN
            state_q     <= ST_RUN;
`endif
        end else begin
            presc_q     <= presc_d;
            mode_q      <= mode;
            cur_sel     <= sel_d;
            dout        <= dout_d;
            valid       <= valid_d;
            chan_strobe <= (sel_d != cur_sel);
`ifdef SCAN_MUX_BLANK_EN
            state_q     <= state_d;
`endif
        end
    end

endmodule

// File: doc/scan_mux_nch.md
Name: scan_mux_nch

Overview:
- Parametrised, registered N-channel, W-bit selector; successor to the fixed 4-to-1 16-bit display multiplexer.
- Adds an auto-scan mode: an internal prescaler rotates through the enabled channels, skipping masked ones, for time-multiplexed seven-segment/LED display driving.
- Also supports a manual mode driven by an external select.
- Sits between the game score/state registers and the display digit driver.

Parameters:
- WIDTH, 16, data width per channel (>=1)
- NCH, 4, number of input channels (2..2**SEL_W)
- SEL_W, 2, select/index width
- PERIOD, 50000, clock cycles per channel slot in auto mode (>=2)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = manual select, 1 = auto scan
- sel_in  in  SEL_W  channel index used in manual mode
- en_mask  in  NCH  per-channel enable; bit i=1 means channel i participates in auto scan
- din  in  NCH*WIDTH  flattened inputs; channel i = din[i*WIDTH +: WIDTH]
- dout  out  WIDTH  registered selected data
- cur_sel  out  SEL_W  index of the channel currently driven on dout
- valid  out  1  dout holds live channel data
- chan_strobe  out  1  one-cycle pulse on the cycle cur_sel changes value

Behaviour:
- Reset (async, rst=1): dout=0, cur_sel=0, valid=0, chan_strobe=0, prescaler=0. First update occurs on the first rising clk after rst deasserts.
- All outputs are registered. Latency is 1 clk from din/sel_in/mode to dout. din changes on the selected channel appear on dout the next cycle, with no extra hold.
- Manual mode (mode=0):
  - Each cycle: cur_sel<=sel_in; dout<=din[sel_in]; valid<=1.
  - If sel_in>=NCH: dout<=0, valid<=0, cur_sel<=sel_in.
  - en_mask is ignored. The prescaler is held at 0.
- Auto mode (mode=1):
  - The prescaler counts 0..PERIOD-1 and wraps. "tick" = the cycle the prescaler equals PERIOD-1.
  - On tick: cur_sel advances to the next index k>cur_sel (mod NCH, wrap NCH-1 -> 0) with en_mask[k]=1. The search covers at most NCH-1 steps. If only cur_sel itself is enabled, cur_sel is unchanged.
  - Every cycle: dout<=din[cur_sel_next]; valid<=en_mask[cur_sel_next].
  - en_mask==0: dout<=0, valid<=0, cur_sel holds; the prescaler keeps running.
  - Current channel disabled mid-slot: dout<=0, valid<=0 immediately (next cycle). cur_sel moves at the next tick.
- Mode switch:
  - 0->1: prescaler cleared to 0; scanning starts from the current cur_sel, or from 0 if cur_sel>=NCH. The first advance occurs PERIOD cycles later.
  - 1->0: takes effect the next cycle; the prescaler is cleared.
- chan_strobe=1 exactly on the cycle following a register update where cur_sel changed (registered compare of old vs new), in either mode. It never asserts when cur_sel is unchanged.
- Prescaler width = smallest width holding PERIOD-1. No overflow is permitted.

Optional Feature:
- Macro: SCAN_MUX_BLANK_EN.
- Defined (auto mode only): on each tick that changes cur_sel, the block enters a 2-cycle BLANK state before driving the new channel. In BLANK:
  - dout=0, valid=0.
  - cur_sel already shows the new index; chan_strobe pulses on the first BLANK cycle.
  - The prescaler continues counting through BLANK, so the slot length stays PERIOD.
  - A mode change or rst during BLANK aborts it immediately.
- Undefined: no BLANK state; the new channel appears on dout on the cycle after tick.
- Manual mode is identical either way.

Test Plan:
- Reset: assert rst mid-scan with cur_sel=2 -> dout=0, cur_sel=0, valid=0 asynchronously, before the next clk edge.
- Manual: din channels = 16'h1111/2222/3333/4444, mode=0, sel_in=2 -> next cycle dout=16'h3333, valid=1, chan_strobe pulses once. Then with NCH=3, sel_in=3 -> dout=0, valid=0.
- Auto full rotation: PERIOD=4, en_mask=4'b1111 -> cur_sel sequence 0,1,2,3,0 changing every 4 cycles; dout tracks 1111,2222,3333,4444,1111; one chan_strobe per change.
- Auto masking: en_mask=4'b1010 from cur_sel=1 -> sequence 1,3,1,3; disabling bit 3 while cur_sel=3 -> next cycle valid=0, dout=0, and cur_sel=1 at the next tick. en_mask=0 -> valid stays 0, cur_sel frozen.
- Mode switch: manual sel_in=2, then mode=1 with PERIOD=4 -> cur_sel=2 for exactly 4 cycles, then 3. Returning to mode=0 with sel_in=0 -> cur_sel=0 the next cycle.
- SCAN_MUX_BLANK_EN defined: PERIOD=8, at the 0->1 advance -> 2 cycles of dout=0, valid=0 with cur_sel=1, then dout=16'h2222 valid=1; next tick still 8 cycles after the previous one.
